gpio_in_debounce: RTL

//   Input conditioning stage for one GPIO port, upstream of the APB GPIO block's PORTIN.
//   Per-pin flow: synchroniser, then debounce filter, then edge detector.

---
 rtl/gpio_in_debounce_pkg.sv | 25 ++
 rtl/gpio_in_debounce_db_pin.sv | 86 ++++++++
 rtl/gpio_in_debounce.sv | 78 +++++++
 3 files changed

// File: rtl/gpio_in_debounce_pkg.sv
// Shared defaults and types for the GPIO input conditioning stage.
//   DEF_*        default parameter values for gpio_in_debounce / gpio_db_pin
//   presc_width  width of the prescaler down-counter for a given divide ratio
//   filt_act_t   per-pin filter decision taken on each clock edge
package gpio_in_debounce_pkg;

    localparam int DEF_PORT_WIDTH  = 8;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_CNT_WIDTH   = 16;
    localparam int DEF_PRESCALE    = 1;

    // At least one bit even for PRESCALE=1, where the counter just sits at 0.
    function automatic int presc_width(input int p);
        return (p > 1) ? $clog2(p) : 1;
    endfunction

    typedef enum logic [2:0] {
        FA_HOLD,    // no tick, mismatch pending: counter holds
        FA_FOLLOW,  // filter disabled: track the synchroniser directly
        FA_CLEAR,   // input agrees with stable level: restart the count
        FA_ACCEPT,  // mismatch lasted long enough: take the new level
        FA_COUNT    // mismatch on a tick: count it
    } filt_act_t;

endpackage

// File: rtl/gpio_in_debounce_db_pin.sv
// One pin of the GPIO input conditioner: synchroniser chain, debounce counter,
// stable level register and registered rise/fall strobes.
//   clk, rst   clock and synchronous active-high reset
//   pin        raw asynchronous pad level
//   tick       sample enable from the shared prescaler
//   bypass     1 = stable level follows the synchroniser
//   db_limit   consecutive mismatching ticks needed to accept a new level
//   stable     debounced level (registered)
//   rise/fall  one-cycle strobes, registered on the edge stable changes
//   edge_nxt   combinational "stable changes on this edge", for the shared CHANGED flop
module gpio_db_pin
    import gpio_in_debounce_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pin,
    input  logic                 tick,
    input  logic                 bypass,
    input  logic [CNT_WIDTH-1:0] db_limit,
    output logic                 stable,
    output logic                 rise,
    output logic                 fall,
    output logic                 edge_nxt
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic                   stable_q;
    logic                   stable_nxt;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [CNT_WIDTH-1:0]   cnt_nxt;
    filt_act_t              act;

    assign sync   = sync_q[SYNC_STAGES-1];
    assign stable = stable_q;

    always_comb begin
        act = FA_HOLD;
        if (bypass || db_limit == '0)
            act = FA_FOLLOW;
        else if (sync == stable_q)
            act = FA_CLEAR;
        else if (!tick)
            act = FA_HOLD;
        // >= rather than == so a limit lowered below the running count
        // accepts on the next tick instead of counting up to a wrap.
        else if (cnt_q >= db_limit - CNT_WIDTH'(1))
            act = FA_ACCEPT;
        else
            act = FA_COUNT;
    end

    always_comb begin
        stable_nxt = stable_q;
        cnt_nxt    = cnt_q;
        case (act)
            FA_FOLLOW: begin stable_nxt = sync; cnt_nxt = '0; end
            FA_CLEAR:  cnt_nxt = '0;
            FA_ACCEPT: begin stable_nxt = sync; cnt_nxt = '0; end
            FA_COUNT:  cnt_nxt = cnt_q + CNT_WIDTH'(1);
            default:   ;
        endcase
    end

    assign edge_nxt = stable_nxt ^ stable_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            rise     <= 1'b0;
            fall     <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], pin};
            stable_q <= stable_nxt;
            cnt_q    <= cnt_nxt;
            rise     <= stable_nxt & ~stable_q;
            fall     <= ~stable_nxt & stable_q;
        end
    end

endmodule

// File: rtl/gpio_in_debounce.sv
// Input conditioning for one GPIO port: per-pin synchroniser, debounce filter
// and edge detector, feeding the GPIO block's PORTIN. All logic on HCLK.
//   HCLK      system clock
//   RESET     synchronous reset, active-high
//   PIN_IN    raw pad levels
//   DB_LIMIT  consecutive mismatching sample ticks needed to accept a level
//             (0 disables filtering for every pin)
//   BYPASS    per-pin filter bypass
//   PORTOUT   debounced levels
//   RISE      one-cycle pulse per pin on PORTOUT 0->1
//   FALL      one-cycle pulse per pin on PORTOUT 1->0
//   CHANGED   OR of RISE|FALL, registered in step with them
// SYNC_STAGES must be in 2..4; PRESCALE must be >= 1.
module gpio_in_debounce
    import gpio_in_debounce_pkg::*;
#(
    parameter int PortWidth   = DEF_PORT_WIDTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
    parameter int PRESCALE    = DEF_PRESCALE
) (
    input  logic                 HCLK,
    input  logic                 RESET,
    input  logic [PortWidth-1:0] PIN_IN,
    input  logic [CNT_WIDTH-1:0] DB_LIMIT,
    input  logic [PortWidth-1:0] BYPASS,
    output logic [PortWidth-1:0] PORTOUT,
    output logic [PortWidth-1:0] RISE,
    output logic [PortWidth-1:0] FALL,
    output logic                 CHANGED
);

    localparam int PW = presc_width(PRESCALE);

    logic [PW-1:0]        pre_q;
    logic                 tick;
    logic [PortWidth-1:0] edge_nxt;

    // Down-counter starts at 0 out of reset, so the first edge after reset
    // is a tick; afterwards one tick every PRESCALE cycles.
    assign tick = (pre_q == '0);

    always_ff @(posedge HCLK) begin
        if (RESET)
            pre_q <= '0;
        else if (tick)
            pre_q <= PW'(PRESCALE - 1);
        else
            pre_q <= pre_q - PW'(1);
    end

    for (genvar i = 0; i < PortWidth; i++) begin : g_pin
        gpio_db_pin #(
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_WIDTH   (CNT_WIDTH)
        ) u_pin (
            .clk      (HCLK),
            .rst      (RESET),
            .pin      (PIN_IN[i]),
            .tick     (tick),
            .bypass   (BYPASS[i]),
            .db_limit (DB_LIMIT),
            .stable   (PORTOUT[i]),
            .rise     (RISE[i]),
            .fall     (FALL[i]),
            .edge_nxt (edge_nxt[i])
        );
    end

    // Built from the pins' next-edge flags so it lands on the same edge as RISE/FALL.
    always_ff @(posedge HCLK) begin
        if (RESET)
            CHANGED <= 1'b0;
        else
            CHANGED <= |edge_nxt;
    end

endmodule
